// File: rtl/arrow_chart_sequencer.sv
// arrow_chart_sequencer: reads a step chart from a synchronous ROM, one 4-bit {L,U,D,R} row
// per ROW_PITCH frames. It paces rows on frame_tick and drives shiftUp/stripArrows into the
// arrow-scroll stage.
// Optional feature: define CHART_LOOP_EN to make the end marker (4'hF) loop the chart back to
// row 0 instead of finishing the song.
module arrow_chart_sequencer #(
    parameter int unsigned ROW_PITCH = 80,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] chart_addr,
    input  logic [3:0]        chart_data,
    output logic              shiftUp,
    output logic [3:0]        stripArrows,
    output logic [ADDR_W-1:0] row_index,
    output logic              song_done,
    output logic              busy
);

    localparam int unsigned CNT_W = (ROW_PITCH > 1) ? $clog2(ROW_PITCH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROW_PITCH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] PLAY  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] scroll_cnt_q;
    logic [3:0]       row_buf_q;
    logic             row_vld_q;
    // 0: address being presented this cycle, 1: ROM data valid this cycle
    logic             fetch_ph_q;

    logic tick_ok;
    logic boundary;

    // Patterns with three arrows cannot be decoded by the scroll stage; blank them.
    function automatic logic [3:0] sanitize(input logic [3:0] p);
        logic [2:0] n;
        n = {2'b00, p[0]} + {2'b00, p[1]} + {2'b00, p[2]} + {2'b00, p[3]};
        return (n > 3'd2) ? 4'h0 : p;
    endfunction

    // Accepted tick and whether it lands on a row boundary with a loaded row
    always_comb begin
        tick_ok  = (state_q == PLAY) && frame_tick && !pause;
        boundary = (scroll_cnt_q == LAST_CNT) && row_vld_q;
    end

    // Busy while a chart is being fetched or played
    always_comb begin
        busy = (state_q == FETCH) || (state_q == PLAY);
    end

    // Sequencer state, row fetch engine and registered scroll outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            chart_addr   <= '0;
            scroll_cnt_q <= '0;
            row_buf_q    <= 4'h0;
            row_vld_q    <= 1'b0;
            fetch_ph_q   <= 1'b0;
            shiftUp      <= 1'b0;
            stripArrows  <= 4'h0;
            row_index    <= '0;
            song_done    <= 1'b0;
        end else if (start) begin
            // Restart from any state; a coincident frame_tick is dropped
            state_q      <= FETCH;
            chart_addr   <= '0;
            scroll_cnt_q <= '0;
            row_vld_q    <= 1'b0;
            fetch_ph_q   <= 1'b0;
            shiftUp      <= 1'b0;
            stripArrows  <= 4'h0;
            row_index    <= '0;
            song_done    <= 1'b0;
        end else begin
            // Two-cycle ROM read, shared by the initial fetch and background refetches
            if (busy && !row_vld_q) begin
                if (!fetch_ph_q) begin
                    fetch_ph_q <= 1'b1;
                end else begin
                    row_buf_q  <= chart_data;
                    row_vld_q  <= 1'b1;
                    fetch_ph_q <= 1'b0;
                    if (state_q == FETCH) begin
                        state_q <= PLAY;
                    end
                end
            end

            if (tick_ok) begin
                if (boundary) begin
                    scroll_cnt_q <= '0;
                    if (row_buf_q != 4'hF) begin
                        shiftUp     <= 1'b1;
                        stripArrows <= sanitize(row_buf_q);
                        row_index   <= row_index + ADDR_W'(1);
                        chart_addr  <= chart_addr + ADDR_W'(1);
                        row_vld_q   <= 1'b0;
                        fetch_ph_q  <= 1'b0;
                    end else begin
`ifdef CHART_LOOP_EN
                        shiftUp     <= 1'b1;
                        stripArrows <= 4'h0;
                        row_index   <= row_index + ADDR_W'(1);
                        chart_addr  <= '0;
                        row_vld_q   <= 1'b0;
                        fetch_ph_q  <= 1'b0;
`else
                        state_q     <= DONE;
                        shiftUp     <= 1'b0;
                        stripArrows <= 4'h0;
                        song_done   <= 1'b1;
`endif
                    end
                end else begin
                    if (scroll_cnt_q != LAST_CNT) begin
                        scroll_cnt_q <= scroll_cnt_q + CNT_W'(1);
                    end
                    shiftUp     <= 1'b0;
                    stripArrows <= 4'h0;
                end
            end
        end
    end

endmodule
